alu_muldiv_seq: RTL

- Multi-cycle sequencer that borrows the shared 32-bit ALU to execute the RISC-V M-subset unsigned ops MUL, MULHU, DIVU and REMU.
- Sits beside the EX stage. While it owns the ALU (alu_own=1), the EX operand mux routes alu_a/alu_b/alu_sel from this block, and EX stalls.
- Shift-add multiply and restoring divide, one ALU operation per cycle, 32 iterations.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_muldiv_seq_step.sv | 45 ++++
 rtl/alu_muldiv_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, mul/div op codes and sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_MULHU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_REMU  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/alu_muldiv_seq_step.sv
// One iteration of shift-add multiply or restoring divide, using the shared ALU result.
module muldiv_step
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] mc,
    input  logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_sel,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] s;
    logic          carry;
    logic          ge;

    always_comb begin
        s     = {hi, lo[XLEN-1]};
        carry = 1'b0;
        ge    = 1'b0;
        if (is_div) begin
            // hi holds the partial remainder, lo shifts dividend bits out and quotient bits in
            alu_a   = s[XLEN-1:0];
            alu_b   = mc;
            alu_sel = ALU_SUB;
            ge      = s[XLEN] | !(s[XLEN-1:0] < mc);
            hi_nxt  = ge ? alu_out : s[XLEN-1:0];
            lo_nxt  = {lo[XLEN-2:0], ge};
        end else begin
            alu_a   = hi;
            alu_b   = lo[0] ? mc : '0;
            alu_sel = ALU_ADD;
            carry   = (alu_out < hi);
            hi_nxt  = {carry, alu_out[XLEN-1:1]};
            lo_nxt  = {alu_out[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL/MULHU/DIVU/REMU sequencer that borrows the shared EX-stage ALU.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] alu_out
);

    logic [1:0]      state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]      op;
    logic [XLEN-1:0] r_hi, r_lo, r_mc;
    logic [XLEN-1:0] hi_nxt, lo_nxt, step_a, step_b;
    logic [3:0]      step_sel;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign alu_own   = (state == ST_RUN);
    assign alu_a     = alu_own ? step_a   : '0;
    assign alu_b     = alu_own ? step_b   : '0;
    assign alu_sel   = alu_own ? step_sel : ALU_ADD;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op[1]),
        .hi      (r_hi),
        .lo      (r_lo),
        .mc      (r_mc),
        .alu_out (alu_out),
        .alu_a   (step_a),
        .alu_b   (step_b),
        .alu_sel (step_sel),
        .hi_nxt  (hi_nxt),
        .lo_nxt  (lo_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            cnt       <= '0;
            op        <= MD_MUL;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mc      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op   <= req_op;
                        cnt  <= '0;
                        r_hi <= '0;
                        // divide by zero short-circuits with the RISC-V defined results
                        if (req_op[1] && req_b == '0) begin
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= (req_op == MD_DIVU) ? '1 : req_a;
                        end else begin
                            state <= ST_RUN;
                            r_lo  <= req_op[1] ? req_a : req_b;
                            r_mc  <= req_op[1] ? req_b : req_a;
                        end
                    end
                end
                ST_RUN: begin
                    r_hi <= hi_nxt;
                    r_lo <= lo_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= (op == MD_MUL || op == MD_DIVU) ? lo_nxt : hi_nxt;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
